error_support_gen: RTL

Generates the ROLLO error support E: `wr` linearly independent elements of GF(2^m) built from the shared 96-bit RNG. It stores them in a small register file. It sits directly upstream of the ciphertext-vector generation controller, which it feeds in two ways:
- its `done` pulse drives the controller's `start`;
- its read port answers the controller's `E_rw`/`E_addr`/`E_ctrlw` requests with `E_dout`, which connects to the controller's `E_din`.

The read port returns either a single basis element or an XOR combination of basis elements.

---
 rtl/error_support_gen_pkg.sv | 36 +++
 rtl/error_support_gen_msb_index_enc.sv | 21 ++
 rtl/error_support_gen.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/error_support_gen_pkg.sv
// Shared types and helpers for the ROLLO error-support generator.
// Optional rank check is selected by SUPPORT_RANK_CHECK_EN.
`ifndef M
`define M 8
`endif
`ifndef Wr
`define Wr 4
`endif

package error_support_gen_pkg;

  localparam int unsigned RNG_W = 96;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_REDUCE,
    S_COMMIT,
    S_DONE
  } state_e;

  // Ceiling log2 with a floor of 1 so single-entry ranges still get a bit.
  function automatic int unsigned CLOG2(input int unsigned n);
    int unsigned r;
    r = 1;
    while ((64'd1 << r) < 64'(n)) r++;
    return r;
  endfunction

  // RNG words needed to fill one m-bit candidate.
  function automatic int unsigned rw_words(input int unsigned m);
    return (m + RNG_W - 1) / RNG_W;
  endfunction

endpackage

// File: rtl/error_support_gen_msb_index_enc.sv
// Combinational priority encoder: index of the most significant set bit.
// An all-zero input yields index 0; callers qualify with a nonzero test.
module msb_index_enc
  import error_support_gen_pkg::*;
#(
  parameter int unsigned m = 8
) (
  input  logic [m-1:0]          v_i,
  output logic [CLOG2(m)-1:0]   idx_o
);

  localparam int unsigned PW = CLOG2(m);

  always_comb begin
    idx_o = '0;
    for (int unsigned k = 0; k < m; k++) begin
      if (v_i[k]) idx_o = PW'(k);
    end
  end

endmodule

// File: rtl/error_support_gen.sv
// Builds wr linearly independent GF(2^m) elements from the shared RNG and
// serves them on a read port. SUPPORT_RANK_CHECK_EN enables the echelon check.
module error_support_gen
  import error_support_gen_pkg::*;
#(
  parameter int unsigned m  = `M,
  parameter int unsigned wr = `Wr,
  parameter int unsigned RW = rw_words(m)
) (
  input  logic                  clk,
  input  logic                  rst_b,
  input  logic                  start,
  output logic                  rng_start,
  input  logic                  rng_finish,
  input  logic [RNG_W-1:0]      rng_data,
  input  logic                  E_rw,
  input  logic [CLOG2(wr)-1:0]  E_addr,
  input  logic [wr:0]           E_ctrlw,
  output logic [m-1:0]          E_dout,
  output logic                  done,
  output logic                  ready,
  output logic [7:0]            reject_cnt
);

  localparam int unsigned IW    = CLOG2(wr);
  localparam int unsigned CW    = CLOG2(wr + 1);
  localparam int unsigned PW    = CLOG2(m);
  localparam int unsigned WW    = CLOG2(RW + 1);
  localparam int unsigned BUF_W = RW * RNG_W;

  state_e             state_q;
  logic [m-1:0]       e_q [wr];
  logic [CW-1:0]      cnt_q;
  logic [BUF_W-1:0]   cand_q;
  logic [WW-1:0]      wcnt_q;
  logic [m-1:0]       v_q;
  logic               rng_start_q;
  logic               done_q;
  logic               ready_q;
  logic [7:0]         rej_q;
  logic [m-1:0]       dout_q;

`ifdef SUPPORT_RANK_CHECK_EN
  logic [m-1:0]       r_q   [wr];
  logic [PW-1:0]      piv_q [wr];
  logic [CW-1:0]      i_q;
`endif

  logic [BUF_W-1:0]   cand_next_c;
  logic [m-1:0]       cand_top_c;
  logic [PW-1:0]      piv_c;
  logic [m-1:0]       rd_c;

  // New words enter at the low end, so the first word ends up most significant.
  assign cand_next_c = (cand_q << RNG_W) | BUF_W'(rng_data);
  assign cand_top_c  = cand_q[BUF_W-1 -: m];

  msb_index_enc #(.m(m)) u_msb_index_enc (
    .v_i   (v_q),
    .idx_o (piv_c)
  );

  // Read port: single element or XOR combination under mask.
  always_comb begin
    rd_c = '0;
    if (E_ctrlw[wr]) begin
      for (int unsigned j = 0; j < wr; j++) begin
        if (E_ctrlw[j]) rd_c = rd_c ^ e_q[j];
      end
    end else if (32'(E_addr) < wr) begin
      rd_c = e_q[E_addr];
    end
  end

`ifdef SUPPORT_RANK_CHECK_EN
  logic unused_sig;
  assign unused_sig = E_rw;
`else
  logic unused_sig;
  assign unused_sig = E_rw ^ (^piv_c);
`endif

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      cand_q      <= '0;
      wcnt_q      <= '0;
      v_q         <= '0;
      rng_start_q <= 1'b0;
      done_q      <= 1'b0;
      ready_q     <= 1'b0;
      rej_q       <= 8'd0;
      dout_q      <= '0;
      for (int unsigned k = 0; k < wr; k++) e_q[k] <= '0;
`ifdef SUPPORT_RANK_CHECK_EN
      i_q <= '0;
      for (int unsigned k = 0; k < wr; k++) begin
        r_q[k]   <= '0;
        piv_q[k] <= '0;
      end
`endif
    end else begin
      rng_start_q <= 1'b0;
      done_q      <= 1'b0;
      dout_q      <= rd_c;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            cnt_q       <= '0;
            wcnt_q      <= '0;
            rej_q       <= 8'd0;
            ready_q     <= 1'b0;
            for (int unsigned k = 0; k < wr; k++) e_q[k] <= '0;
`ifdef SUPPORT_RANK_CHECK_EN
            for (int unsigned k = 0; k < wr; k++) begin
              r_q[k]   <= '0;
              piv_q[k] <= '0;
            end
`endif
            rng_start_q <= 1'b1;
            state_q     <= S_REQ;
          end
        end
        S_REQ: state_q <= S_WAIT;
        S_WAIT: begin
          if (rng_finish) begin
            cand_q <= cand_next_c;
            if (wcnt_q == WW'(RW - 1)) begin
              wcnt_q <= '0;
              v_q    <= cand_next_c[BUF_W-1 -: m];
`ifdef SUPPORT_RANK_CHECK_EN
              i_q     <= '0;
              state_q <= S_REDUCE;
`else
              state_q <= S_COMMIT;
`endif
            end else begin
              wcnt_q      <= wcnt_q + 1'b1;
              rng_start_q <= 1'b1;
              state_q     <= S_REQ;
            end
          end
        end
`ifdef SUPPORT_RANK_CHECK_EN
        // One elimination step per cycle against the stored echelon rows.
        S_REDUCE: begin
          if (i_q < cnt_q) begin
            if (v_q[piv_q[IW'(i_q)]]) v_q <= v_q ^ r_q[IW'(i_q)];
            i_q <= i_q + 1'b1;
          end else begin
            state_q <= S_COMMIT;
          end
        end
`endif
        S_COMMIT: begin
          if (v_q != '0) begin
            e_q[IW'(cnt_q)] <= cand_top_c;
`ifdef SUPPORT_RANK_CHECK_EN
            r_q[IW'(cnt_q)]   <= v_q;
            piv_q[IW'(cnt_q)] <= piv_c;
`endif
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CW'(wr - 1)) begin
              done_q  <= 1'b1;
              ready_q <= 1'b1;
              state_q <= S_DONE;
            end else begin
              rng_start_q <= 1'b1;
              state_q     <= S_REQ;
            end
          end else begin
            if (rej_q != 8'hFF) rej_q <= rej_q + 8'd1;
            rng_start_q <= 1'b1;
            state_q     <= S_REQ;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rng_start  = rng_start_q;
  assign done       = done_q;
  assign ready      = ready_q;
  assign reject_cnt = rej_q;
  assign E_dout     = dout_q;

endmodule
